// File: rtl/bitdeposit_iter_if.sv
// Request/result bus for bitdeposit_iter: request in, result out, plus busy status.
interface bitdeposit_iter_if;
    localparam int unsigned W = 32;

    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] din_value;
    logic [W-1:0] din_mask;
    logic         din_extract;
    logic         dout_valid;
    logic         dout_ready;
    logic [W-1:0] dout;
    logic         busy;

    modport master (
        output din_valid, din_value, din_mask, din_extract, dout_ready,
        input  din_ready, dout_valid, dout, busy
    );

    modport slave (
        input  din_valid, din_value, din_mask, din_extract, dout_ready,
        output din_ready, dout_valid, dout, busy
    );
endinterface

// File: rtl/bitdeposit_iter.sv
// Iterative bit deposit/extract, one mask bit per clock.
// Extract mode is built only when BITDEPOSIT_EXTRACT_EN is defined; otherwise every request deposits.
module bitdeposit_iter (
    input  logic              clk,
    input  logic              resetn,
    bitdeposit_iter_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned KW = 6;
    localparam int unsigned IW = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic [W-1:0]   value_q;
    logic [W-1:0]   m_q;
    logic [KW-1:0]  k_q;
    logic [W-1:0]   low_bit;
    logic [W-1:0]   bit_term;
`ifdef BITDEPOSIT_EXTRACT_EN
    logic           mode_q;
    logic           ext_bit;
`endif

    // Next-state decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (bus.din_valid) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN:  if (m_q == '0) state_next = DONE;
            DONE: if (bus.dout_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lowest set bit of the remaining mask marks the position handled this cycle
    always_comb begin
        low_bit  = m_q & (~m_q + W'(1));
        bit_term = value_q[k_q[IW-1:0]] ? low_bit : '0;
`ifdef BITDEPOSIT_EXTRACT_EN
        ext_bit  = |(value_q & low_bit);
        if (mode_q) bit_term = W'(ext_bit) << k_q[IW-1:0];
`endif
    end

    // State and status flags, registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            bus.din_ready  <= 1'b1;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_next;
            bus.din_ready  <= (state_next == IDLE);
            bus.dout_valid <= (state_next == DONE);
            bus.busy       <= (state_next != IDLE);
        end
    end

    // Operand capture and per-bit accumulation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q  <= '0;
            m_q      <= '0;
            k_q      <= '0;
            bus.dout <= '0;
`ifdef BITDEPOSIT_EXTRACT_EN
            mode_q   <= 1'b0;
`endif
        end else if (accept) begin
            value_q  <= bus.din_value;
            m_q      <= bus.din_mask;
            k_q      <= '0;
            bus.dout <= '0;
`ifdef BITDEPOSIT_EXTRACT_EN
            mode_q   <= bus.din_extract;
`endif
        end else if (state == RUN && m_q != '0) begin
            bus.dout <= bus.dout | bit_term;
            k_q      <= k_q + KW'(1);
            m_q      <= m_q & (m_q - W'(1));
        end
    end
endmodule

// File: tb/tb_bitdeposit_iter.sv
// Directed, table-driven bench for bitdeposit_iter with hand-computed results and latencies.
module tb_bitdeposit_iter;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bitdeposit_iter_if bus ();
    bitdeposit_iter dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [31:0] value;
        logic [31:0] mask;
        logic        ext;
        logic [31:0] exp;
        int          lat;
        string       tag;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] v, input logic [31:0] m, input logic e,
                          input logic [31:0] exp, input int lat, input string tag,
                          input bit release_res);
        int cnt;
        @(negedge clk);
        check({tag, "_din_ready"}, 32'(bus.din_ready), 32'd1);
        bus.din_valid   = 1'b1;
        bus.din_value   = v;
        bus.din_mask    = m;
        bus.din_extract = e;
        @(posedge clk); #1;
        bus.din_valid   = 1'b0;
        bus.din_value   = $urandom;
        bus.din_mask    = $urandom;
        bus.din_extract = ~e;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cnt = 0;
        while (bus.dout_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(lat));
        check({tag, "_dout"}, bus.dout, exp);
        if (release_res) begin
            @(negedge clk);
            bus.dout_ready = 1'b1;
            @(posedge clk); #1;
            check({tag, "_idle_ready"}, 32'(bus.din_ready), 32'd1);
            check({tag, "_idle_valid"}, 32'(bus.dout_valid), 32'd0);
            bus.dout_ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000000F, 32'h0F0F0000, 1'b0, 32'h000F0000, 9,  "dep_basic"};
`ifdef BITDEPOSIT_EXTRACT_EN
        vecs[1] = '{32'h12345678, 32'h0000FF00, 1'b1, 32'h00000056, 9,  "ext_byte"};
        vecs[6] = '{32'h80000001, 32'h80000001, 1'b1, 32'h00000003, 3,  "ext_edges"};
        vecs[8] = '{32'hF0F0F0F0, 32'hFFFF0000, 1'b1, 32'h0000F0F0, 17, "ext_half"};
`else
        vecs[1] = '{32'h12345678, 32'h0000FF00, 1'b1, 32'h00007800, 9,  "ext_byte"};
        vecs[6] = '{32'h80000001, 32'h80000001, 1'b1, 32'h00000001, 3,  "ext_edges"};
        vecs[8] = '{32'hF0F0F0F0, 32'hFFFF0000, 1'b1, 32'hF0F00000, 17, "ext_half"};
`endif
        vecs[2] = '{32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000, 1,  "mask_zero"};
        vecs[3] = '{32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 32'hA5A5A5A5, 33, "mask_ones"};
        vecs[4] = '{32'h00000003, 32'h00000011, 1'b0, 32'h00000011, 3,  "dep_two"};
        vecs[5] = '{32'h00000005, 32'h80000001, 1'b0, 32'h00000001, 3,  "dep_edges"};
        vecs[7] = '{32'hFFFFFFFF, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA, 17, "dep_alt"};
        vecs[9] = '{32'hFFFFFFFE, 32'h00000100, 1'b0, 32'h00000000, 2,  "dep_zero_bit"};

        bus.din_valid   = 1'b0;
        bus.din_value   = '0;
        bus.din_mask    = '0;
        bus.din_extract = 1'b0;
        bus.dout_ready  = 1'b0;

        #2 resetn = 1'b0;
        #1;
        check("rst_din_ready",  32'(bus.din_ready),  32'd1);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_dout",       bus.dout,            32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].value, vecs[i].mask, vecs[i].ext, vecs[i].exp, vecs[i].lat, vecs[i].tag, 1'b1);

        // dout_ready held high throughout RUN must not shorten the operation
        bus.dout_ready = 1'b1;
        run_op(32'h000000FF, 32'h0000F00F, 1'b0, 32'h0000F00F, 9, "ready_early", 1'b1);

        // Backpressure: result held for 5 cycles while a new request is offered
        run_op(32'h0000000F, 32'h0F0F0000, 1'b0, 32'h000F0000, 9, "bp", 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.din_valid = 1'b1;
            bus.din_value = $urandom;
            bus.din_mask  = $urandom;
            @(posedge clk); #1;
            check("bp_hold_dout",  bus.dout,            32'h000F0000);
            check("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.din_ready),  32'd0);
        end
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(bus.din_ready),  32'd1);
        check("bp_release_valid", 32'(bus.dout_valid), 32'd0);
        check("bp_release_busy",  32'(bus.busy),       32'd0);
        bus.dout_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_stay_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a long operation
        @(negedge clk);
        bus.din_valid = 1'b1;
        bus.din_value = 32'h5A5A5A5A;
        bus.din_mask  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_din_ready",  32'(bus.din_ready),  32'd1);
        check("mid_rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("mid_rst_busy",       32'(bus.busy),       32'd0);
        check("mid_rst_dout",       bus.dout,            32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("mid_rst_no_valid", 32'(bus.dout_valid), 32'd0);
        end
        @(negedge clk) resetn = 1'b1;
        run_op(32'h00000003, 32'h00000011, 1'b0, 32'h00000011, 3, "post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
